// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG constants: block size, zigzag table, coefficient width, read FSM states
package jpeg_pkg;

  localparam int BLK_SIZE = 64;
  localparam int COEF_DW  = 12;

  // zigzag position -> raster index (row*8+col)
  localparam logic [5:0] ZZ [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/zz_bank.sv
// rtl/zz_bank.sv - 64-entry flop bank, one write port and one combinational read port
module zz_bank
  import jpeg_pkg::*;
#(
  parameter int DW = COEF_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [5:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [5:0]    raddr,
  output logic [DW-1:0] rdata
);

  // contents are deliberately left unreset; the full flags in the parent gate their use
  logic [DW-1:0] mem [BLK_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mdct_zigzag.sv
// rtl/mdct_zigzag.sv - ping-pong raster-to-zigzag reorder for 8x8 MDCT blocks
// Optional macro ZZ_EOB_MARK_EN adds an eob output marking zigzag position 63.
module mdct_zigzag
  import jpeg_pkg::*;
#(
  parameter int DW = COEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dcti,
  input  logic          idv,
  output logic [DW-1:0] zzo,
  output logic          odv,
  input  logic          ordy,
  output logic          sob,
  output logic          ovf
`ifdef ZZ_EOB_MARK_EN
  ,
  output logic          eob
`endif
);

  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          wb;
  logic          rb;
  logic [5:0]    wcnt;
  logic [5:0]    rcnt;
  rd_state_t     st;

  logic          last_xfer;
  logic          wr_busy;
  logic          wr_acc;
  logic          swap;
  logic [5:0]    raddr;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rd_sel;

  // odv is always high in DRAIN, so ordy alone marks a transfer; rcnt==0 means position 63 is on zzo
  always_comb begin
    last_xfer = (st == RD_DRAIN) && ordy && (rcnt == 6'd0);
    wr_busy   = full[wb] && !(last_xfer && (rb == wb));
    wr_acc    = idv && !wr_busy;
    swap      = last_xfer && full[~rb];
    raddr     = ZZ[rcnt];
    rd_sel    = (rb ^ swap) ? rdata1 : rdata0;
    full_n    = full;
    if (last_xfer) full_n[rb] = 1'b0;
    if (wr_acc && (wcnt == 6'd63)) full_n[wb] = 1'b1;
  end

  zz_bank #(.DW(DW)) u_bank0 (
    .clk   (clk),
    .we    (wr_acc && !wb),
    .waddr (wcnt),
    .wdata (dcti),
    .raddr (raddr),
    .rdata (rdata0)
  );

  zz_bank #(.DW(DW)) u_bank1 (
    .clk   (clk),
    .we    (wr_acc && wb),
    .waddr (wcnt),
    .wdata (dcti),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
      wb   <= 1'b0;
      rb   <= 1'b0;
      wcnt <= 6'd0;
      rcnt <= 6'd0;
      st   <= RD_IDLE;
      zzo  <= '0;
      odv  <= 1'b0;
      sob  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_acc) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == 6'd63) wb <= ~wb;
      end
      if (idv && wr_busy) ovf <= 1'b1;

      case (st)
        RD_IDLE: begin
          if (full[rb]) begin
            zzo  <= rd_sel;
            odv  <= 1'b1;
            sob  <= 1'b1;
            rcnt <= 6'd1;
            st   <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (ordy) begin
            if (rcnt != 6'd0) begin
              zzo  <= rd_sel;
              sob  <= 1'b0;
              rcnt <= rcnt + 6'd1;
            end else begin
              rb <= ~rb;
              // chain straight into the other bank when it is already waiting
              if (full[~rb]) begin
                zzo  <= rd_sel;
                sob  <= 1'b1;
                rcnt <= 6'd1;
              end else begin
                odv <= 1'b0;
                sob <= 1'b0;
                st  <= RD_IDLE;
              end
            end
          end
        end
        default: st <= RD_IDLE;
      endcase
    end
  end

`ifdef ZZ_EOB_MARK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      eob <= 1'b0;
    end else if ((st == RD_DRAIN) && ordy) begin
      eob <= (rcnt == 6'd63);
    end
  end
`endif

endmodule
